opbomp_frame_loader: RTL

Upstream stage of OPBOMP. It accepts one measurement sample per valid/ready beat, packs N_SAMPLES samples into the 384-bit measurement vector x, and presents each completed frame to OPBOMP with a valid/ready handshake. A separate fill register and output register let the next frame fill while OPBOMP holds the current x. The block also checks frame delimiting via s_last and resynchronises when a frame is malformed.

---
 rtl/opbomp_frame_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/opbomp_frame_loader.sv
// Packs N_SAMPLES beats into x; frame is presented 1 cycle after its last beat and held while x_ready=0.
// Backpressure stalls only the final beat of a frame while x is still occupied; s_last checks drive resync via DROP.
module opbomp_frame_loader #(
  parameter int SAMPLE_W  = 16,
  parameter int N_SAMPLES = 24,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [SAMPLE_W-1:0]             s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic [SAMPLE_W*N_SAMPLES-1:0]   x,
  output logic                            x_valid,
  input  logic                            x_ready,
  output logic                            frame_err,
  output logic [CNT_W-1:0]                frame_cnt
);
  localparam int X_W   = SAMPLE_W * N_SAMPLES;
  localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  typedef enum logic {FILL, DROP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SAMPLE_W-1:0] fill_q [N_SAMPLES];
  logic [X_W-1:0]      frame_new;
  logic                last_slot, accept, fill_wr, frame_done, err_d;

  assign last_slot = (idx_q == LAST_IDX);
  // Only the final beat waits on the output register; earlier beats land in the fill register.
  assign s_ready   = rst_n && !(state_q == FILL && last_slot && x_valid && !x_ready);
  assign accept    = s_valid && s_ready;

  always_comb begin
    frame_new = '0;
    for (int k = 0; k < N_SAMPLES - 1; k++) begin
      frame_new[k*SAMPLE_W +: SAMPLE_W] = fill_q[k];
    end
    frame_new[(N_SAMPLES-1)*SAMPLE_W +: SAMPLE_W] = s_data;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fill_wr    = 1'b0;
    frame_done = 1'b0;
    err_d      = 1'b0;
    if (accept) begin
      case (state_q)
        FILL: begin
          if (!last_slot) begin
            if (s_last) begin
              err_d = 1'b1;
              idx_d = '0;
            end else begin
              fill_wr = 1'b1;
              idx_d   = idx_q + 1'b1;
            end
          end else begin
            idx_d = '0;
            if (s_last) begin
              frame_done = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = DROP;
            end
          end
        end
        DROP: begin
          if (s_last) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      frame_err <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SAMPLES; k++) fill_q[k] <= '0;
    end else if (fill_wr) begin
      fill_q[idx_q] <= s_data;
    end
  end

  // frame_done can only fire when x is free or being consumed, so a held x is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      x_valid   <= 1'b0;
      frame_cnt <= '0;
    end else if (frame_done) begin
      x         <= frame_new;
      x_valid   <= 1'b1;
      frame_cnt <= frame_cnt + 1'b1;
    end else if (x_valid && x_ready) begin
      x_valid   <= 1'b0;
    end
  end

endmodule
